pmt_fbc_frame_unpack: RTL and testbench

- Receive-side unpacker for the 64-bit PMT/FBC word stream produced by the timing board's encode cache and carried over Aurora.
- Consumes words from the receive FIFO via valid/ready, checks the 4-word frame order (tags 0,1,2,3) and reassembles one frame of encode W/X plus FBCi/FBCr1/FBCr2 A/B samples.
- Outputs one registered frame per handshake, with frame/error counters and end-of-transfer flush.
- Sits on the PCIe-board side between the Aurora RX FIFO and the scan-data DMA packer.

---
 rtl/pmt_fbc_pkg.sv | 35 +++
 rtl/pmt_fbc_word_decode.sv | 46 ++++
 rtl/pmt_fbc_frame_unpack.sv | 185 ++++++++++++++++++
 tb/tb_pmt_fbc_frame_unpack.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmt_fbc_pkg.sv
// Shared definitions for the PMT/FBC receive unpacker: word tags, field bit positions, FSM states.
// No logic; latency and backpressure are defined by the modules that import this package.
package pmt_fbc_pkg;

  localparam logic [1:0] TAG_ENC   = 2'd0;
  localparam logic [1:0] TAG_FBCI  = 2'd1;
  localparam logic [1:0] TAG_FBCR1 = 2'd2;
  localparam logic [1:0] TAG_FBCR2 = 2'd3;

  localparam int WORD_WID   = 64;
  localparam int MARKER_BIT = 63;
  localparam int TAG_LSB    = 61;
  localparam int HI_LSB     = 32;  // W and A fields start here
  localparam int LO_LSB     = 0;   // X and B fields start here
  localparam int ENC_X_WID  = 32;

  // S_T0..S_T3 share their low two bits with the tag they expect
  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_HUNT = 3'd4
  } state_e;

  function automatic state_e state_after(input state_e s);
    case (s)
      S_T0:    state_after = S_T1;
      S_T1:    state_after = S_T2;
      S_T2:    state_after = S_T3;
      default: state_after = S_T0;
    endcase
  endfunction

endpackage

// File: rtl/pmt_fbc_word_decode.sv
// Field extract for one PMT/FBC word: marker, tag, W/X and A/B fields, pad check (PMT_UNPACK_PAD_CHECK_EN).
// Purely combinational, zero latency; no flow control of its own.
module pmt_fbc_word_decode
  import pmt_fbc_pkg::*;
#(
  parameter int ENC_W_WID = 29,
  parameter int FBC_WID   = 24
) (
  input  logic [WORD_WID-1:0]  word_dat,
  output logic                 marker_ok,
  output logic [1:0]           tag,
  output logic [ENC_W_WID-1:0] enc_w,
  output logic [ENC_X_WID-1:0] enc_x,
  output logic [FBC_WID-1:0]   fbc_a,
  output logic [FBC_WID-1:0]   fbc_b,
  output logic                 pad_err
);

  assign marker_ok = word_dat[MARKER_BIT];
  assign tag       = word_dat[TAG_LSB +: 2];
  assign enc_w     = word_dat[HI_LSB +: ENC_W_WID];
  assign enc_x     = word_dat[LO_LSB +: ENC_X_WID];
  assign fbc_a     = word_dat[HI_LSB +: FBC_WID];
  assign fbc_b     = word_dat[LO_LSB +: FBC_WID];

`ifdef PMT_UNPACK_PAD_CHECK_EN
  logic [WORD_WID-1:0] pad_mask;

  // Pad is every payload bit below the tag not covered by the fields of this tag
  always_comb begin
    pad_mask = '0;
    for (int i = LO_LSB; i < TAG_LSB; i++) begin
      if (tag == TAG_ENC) begin
        pad_mask[i] = (i >= HI_LSB + ENC_W_WID);
      end else begin
        pad_mask[i] = (i >= HI_LSB + FBC_WID) || ((i >= LO_LSB + FBC_WID) && (i < HI_LSB));
      end
    end
  end

  assign pad_err = |(word_dat & pad_mask);
`else
  assign pad_err = 1'b0;
`endif

endmodule

// File: rtl/pmt_fbc_frame_unpack.sv
// PMT/FBC RX unpacker: checks tag order 0..3, rebuilds one frame; pad check under PMT_UNPACK_PAD_CHECK_EN.
// Frame valid 1 cycle after the tag-3 word; input stalls only while a frame is held by frame_rdy_i low.
module pmt_fbc_frame_unpack
  import pmt_fbc_pkg::*;
#(
  parameter int ENC_W_WID   = 29,
  parameter int FBC_WID     = 24,
  parameter int ERR_CNT_WID = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clr_i,
  input  logic                   in_vld_i,
  input  logic [WORD_WID-1:0]    in_data_i,
  output logic                   in_rdy_o,
  input  logic                   end_i,
  output logic                   frame_vld_o,
  input  logic                   frame_rdy_i,
  output logic [ENC_W_WID-1:0]   enc_w_o,
  output logic [ENC_X_WID-1:0]   enc_x_o,
  output logic [FBC_WID-1:0]     fbci_a_o,
  output logic [FBC_WID-1:0]     fbci_b_o,
  output logic [FBC_WID-1:0]     fbcr1_a_o,
  output logic [FBC_WID-1:0]     fbcr1_b_o,
  output logic [FBC_WID-1:0]     fbcr2_a_o,
  output logic [FBC_WID-1:0]     fbcr2_b_o,
  output logic [31:0]            frame_cnt_o,
  output logic [ERR_CNT_WID-1:0] seq_err_cnt_o,
  output logic                   seq_err_o,
  output logic                   done_o
);

  state_e               state_q;
  state_e               state_d;
  logic                 marker_ok;
  logic                 pad_err;
  logic [1:0]           tag;
  logic [ENC_W_WID-1:0] w_dat;
  logic [ENC_X_WID-1:0] x_dat;
  logic [FBC_WID-1:0]   a_dat;
  logic [FBC_WID-1:0]   b_dat;
  logic                 acc;
  logic                 end_q;
  logic                 end_rise;
  logic                 cap;
  logic                 emit;
  logic                 err;
  logic                 flush;

  pmt_fbc_word_decode #(
    .ENC_W_WID (ENC_W_WID),
    .FBC_WID   (FBC_WID)
  ) u_decode (
    .word_dat  (in_data_i),
    .marker_ok (marker_ok),
    .tag       (tag),
    .enc_w     (w_dat),
    .enc_x     (x_dat),
    .fbc_a     (a_dat),
    .fbc_b     (b_dat),
    .pad_err   (pad_err)
  );

  assign in_rdy_o = ~(frame_vld_o & ~frame_rdy_i);
  assign acc      = in_vld_i & in_rdy_o;
  assign end_rise = end_i & ~end_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_T0;
    end else begin
      state_q <= state_d;
    end
  end

  // The accepted word is resolved first; a flush in the same cycle then acts on the resulting state
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    emit    = 1'b0;
    err     = 1'b0;
    flush   = 1'b0;
    if (clr_i) begin
      state_d = S_T0;
    end else begin
      if (acc) begin
        if (!marker_ok) begin
          err = 1'b1;
        end else if (state_q == S_HUNT) begin
          if (tag == TAG_ENC) begin
            cap     = 1'b1;
            state_d = S_T1;
          end
        end else if (tag == state_q[1:0]) begin
          cap     = 1'b1;
          emit    = (state_q == S_T3);
          state_d = state_after(state_q);
        end else begin
          err = 1'b1;
          if (tag == TAG_ENC) begin
            cap     = 1'b1;
            state_d = S_T1;
          end else begin
            state_d = S_HUNT;
          end
        end
        if (cap && pad_err) begin
          err = 1'b1;
        end
      end
      if (end_rise) begin
        flush = 1'b1;
        if (state_d inside {S_T1, S_T2, S_T3}) begin
          err = 1'b1;
        end
        state_d = S_T0;
      end
    end
  end

  // Holding registers double as the frame outputs: a new word can only land once the
  // pending frame has handshaken, because in_rdy_o is low while it is blocked
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      enc_w_o   <= '0;
      enc_x_o   <= '0;
      fbci_a_o  <= '0;
      fbci_b_o  <= '0;
      fbcr1_a_o <= '0;
      fbcr1_b_o <= '0;
      fbcr2_a_o <= '0;
      fbcr2_b_o <= '0;
    end else if (cap) begin
      case (tag)
        TAG_ENC: begin
          enc_w_o <= w_dat;
          enc_x_o <= x_dat;
        end
        TAG_FBCI: begin
          fbci_a_o <= a_dat;
          fbci_b_o <= b_dat;
        end
        TAG_FBCR1: begin
          fbcr1_a_o <= a_dat;
          fbcr1_b_o <= b_dat;
        end
        default: begin
          fbcr2_a_o <= a_dat;
          fbcr2_b_o <= b_dat;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      end_q         <= 1'b0;
      frame_vld_o   <= 1'b0;
      frame_cnt_o   <= '0;
      seq_err_cnt_o <= '0;
      seq_err_o     <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      end_q     <= end_i;
      seq_err_o <= err;
      done_o    <= flush;
      if (clr_i) begin
        frame_vld_o   <= 1'b0;
        frame_cnt_o   <= '0;
        seq_err_cnt_o <= '0;
      end else begin
        if (emit) begin
          frame_vld_o <= 1'b1;
          frame_cnt_o <= frame_cnt_o + 32'd1;
        end else if (frame_rdy_i) begin
          frame_vld_o <= 1'b0;
        end
        if (err && (seq_err_cnt_o != {ERR_CNT_WID{1'b1}})) begin
          seq_err_cnt_o <= seq_err_cnt_o + ERR_CNT_WID'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pmt_fbc_frame_unpack.sv
// Directed bench for pmt_fbc_frame_unpack: expected frames queued at stimulus, popped by a monitor on handshake.
module tb_pmt_fbc_frame_unpack;

  typedef struct packed {
    logic [28:0] w;
    logic [31:0] x;
    logic [23:0] ia, ib, r1a, r1b, r2a, r2b;
  } frame_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        clr_i;
  logic        in_vld_i;
  logic [63:0] in_data_i;
  logic        in_rdy_o;
  logic        end_i;
  logic        frame_vld_o;
  logic        frame_rdy_i;
  logic [28:0] enc_w_o;
  logic [31:0] enc_x_o;
  logic [23:0] fbci_a_o, fbci_b_o, fbcr1_a_o, fbcr1_b_o, fbcr2_a_o, fbcr2_b_o;
  logic [31:0] frame_cnt_o;
  logic [15:0] seq_err_cnt_o;
  logic        seq_err_o;
  logic        done_o;

  always #5 clk_i = ~clk_i;

  pmt_fbc_frame_unpack dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .clr_i         (clr_i),
    .in_vld_i      (in_vld_i),
    .in_data_i     (in_data_i),
    .in_rdy_o      (in_rdy_o),
    .end_i         (end_i),
    .frame_vld_o   (frame_vld_o),
    .frame_rdy_i   (frame_rdy_i),
    .enc_w_o       (enc_w_o),
    .enc_x_o       (enc_x_o),
    .fbci_a_o      (fbci_a_o),
    .fbci_b_o      (fbci_b_o),
    .fbcr1_a_o     (fbcr1_a_o),
    .fbcr1_b_o     (fbcr1_b_o),
    .fbcr2_a_o     (fbcr2_a_o),
    .fbcr2_b_o     (fbcr2_b_o),
    .frame_cnt_o   (frame_cnt_o),
    .seq_err_cnt_o (seq_err_cnt_o),
    .seq_err_o     (seq_err_o),
    .done_o        (done_o)
  );

  frame_t sb[$];
  int n_cmp       = 0;
  int n_err       = 0;
  int err_pulses  = 0;
  int done_pulses = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] enc_word(input logic [28:0] ww, input logic [31:0] xx);
    return {1'b1, 2'd0, ww, xx};
  endfunction

  function automatic logic [63:0] fbc_word(input logic [1:0] t, input logic [23:0] a, input logic [23:0] b);
    return {1'b1, t, 5'd0, a, 8'd0, b};
  endfunction

  function automatic frame_t mkf(input logic [28:0] ww, input logic [31:0] xx, input logic [23:0] s);
    mkf = '{w: ww, x: xx, ia: s + 24'd1, ib: s + 24'd2, r1a: s + 24'd3,
            r1b: s + 24'd4, r2a: s + 24'd5, r2b: s + 24'd6};
  endfunction

  // Drives one word from a negedge and returns 1 time unit after the edge that accepted it
  task automatic send(input logic [63:0] wd);
    logic ok;
    int   guard;
    ok    = 1'b0;
    guard = 0;
    @(negedge clk_i);
    in_vld_i  = 1'b1;
    in_data_i = wd;
    while (!ok && guard < 200) begin
      if (guard != 0) @(negedge clk_i);
      ok = in_rdy_o;
      @(posedge clk_i);
      guard++;
    end
    #1;
    in_vld_i = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_rdy_o stayed 0 for %0d cycles, required 1", guard);
    end
  endtask

  task automatic send_frame(input frame_t f);
    send(enc_word(f.w, f.x));
    send(fbc_word(2'd1, f.ia, f.ib));
    send(fbc_word(2'd2, f.r1a, f.r1b));
    send(fbc_word(2'd3, f.r2a, f.r2b));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (seq_err_o) err_pulses++;
      if (done_o) done_pulses++;
      if (frame_vld_o && frame_rdy_i) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame: got frame w=%0h x=%0h, required none", enc_w_o, enc_x_o);
        end else begin
          chk("frame_fields",
              {enc_w_o, enc_x_o, fbci_a_o, fbci_b_o, fbcr1_a_o, fbcr1_b_o, fbcr2_a_o, fbcr2_b_o},
              sb.pop_front());
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    frame_t f, f2, f3;
    int     p0, d0, exp_err;
    rst_n_i = 1'b0; clr_i = 1'b0; in_vld_i = 1'b0; in_data_i = '0;
    end_i = 1'b0; frame_rdy_i = 1'b1; exp_err = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_frame_vld", frame_vld_o, 1'b0);
    chk("rst_in_rdy", in_rdy_o, 1'b1);
    chk("rst_frame_cnt", frame_cnt_o, 0);
    chk("rst_err_cnt", seq_err_cnt_o, 0);
    chk("rst_pulses", {seq_err_o, done_o}, 0);
    chk("rst_fields", {enc_w_o, enc_x_o, fbci_a_o, fbci_b_o, fbcr1_a_o, fbcr1_b_o, fbcr2_a_o, fbcr2_b_o}, 0);

    // Good frame
    f = '{w: 29'h1234, x: 32'h5678, ia: 24'hABCDEF, ib: 24'h123456, r1a: 24'hABCDEF,
          r1b: 24'h123456, r2a: 24'hABCDEF, r2b: 24'h123456};
    sb.push_back(f);
    send_frame(f);
    @(negedge clk_i);
    chk("lat1_frame_vld", frame_vld_o, 1'b1);
    chk("good_frame_cnt", frame_cnt_o, 1);
    chk("good_err_cnt", seq_err_cnt_o, 0);

    // Backpressure: frame 2 held while frame 3 is offered
    @(posedge clk_i);
    #1 frame_rdy_i = 1'b0;
    f2 = mkf(29'h0000222, 32'h2222_0002, 24'h200000);
    f3 = mkf(29'h0333333, 32'h3333_0003, 24'h300000);
    sb.push_back(f2);
    send_frame(f2);
    sb.push_back(f3);
    fork
      send_frame(f3);
      begin
        repeat (5) begin
          @(negedge clk_i);
          chk("bp_in_rdy", in_rdy_o, 1'b0);
          chk("bp_hold", {frame_vld_o, enc_x_o, fbcr2_b_o}, {1'b1, f2.x, f2.r2b});
          chk("bp_frame_cnt", frame_cnt_o, 2);
        end
        @(posedge clk_i);
        #1 frame_rdy_i = 1'b1;
      end
    join
    wait_cycles(2);
    chk("bp_frame_cnt_after", frame_cnt_o, 3);

    // Resync: tags 0,1,3,2,0,1,2,3
    p0 = err_pulses;
    sb.push_back('{w: 29'h1FFFFFFF, x: 32'hCAFEF00D, ia: 24'hA1A1A1, ib: 24'hB1B1B1,
                   r1a: 24'hA2A2A2, r1b: 24'hB2B2B2, r2a: 24'hA3A3A3, r2b: 24'hB3B3B3});
    send(enc_word(29'h0AAA, 32'hDEAD_0001));
    send(fbc_word(2'd1, 24'h111111, 24'h222222));
    send(fbc_word(2'd3, 24'h333333, 24'h444444));
    send(fbc_word(2'd2, 24'h555555, 24'h666666));
    send(enc_word(29'h1FFFFFFF, 32'hCAFEF00D));
    send(fbc_word(2'd1, 24'hA1A1A1, 24'hB1B1B1));
    send(fbc_word(2'd2, 24'hA2A2A2, 24'hB2B2B2));
    send(fbc_word(2'd3, 24'hA3A3A3, 24'hB3B3B3));
    wait_cycles(2);
    exp_err = 1;
    chk("resync_err_cnt", seq_err_cnt_o, exp_err);
    chk("resync_err_pulses", err_pulses - p0, 1);
    chk("resync_frame_cnt", frame_cnt_o, 4);

    // Flush of a partial frame
    p0 = err_pulses;
    d0 = done_pulses;
    send(enc_word(29'h00BEEF, 32'h1));
    send(fbc_word(2'd1, 24'h1, 24'h2));
    end_i = 1'b1;
    wait_cycles(3);
    end_i = 1'b0;
    exp_err++;
    chk("flush_err_cnt", seq_err_cnt_o, exp_err);
    chk("flush_err_pulses", err_pulses - p0, 1);
    chk("flush_done_pulses", done_pulses - d0, 1);
    chk("flush_no_frame", frame_cnt_o, 4);
    wait_cycles(1);
    f = mkf(29'h0555555, 32'h5555_0005, 24'h500000);
    sb.push_back(f);
    send_frame(f);
    wait_cycles(2);
    chk("post_flush_frame_cnt", frame_cnt_o, 5);
    chk("post_flush_err_cnt", seq_err_cnt_o, exp_err);

    // Flush edge coincides with the tag-3 word that completes a frame
    d0 = done_pulses;
    f = mkf(29'h0666666, 32'h6666_0006, 24'h600000);
    sb.push_back(f);
    send(enc_word(f.w, f.x));
    send(fbc_word(2'd1, f.ia, f.ib));
    send(fbc_word(2'd2, f.r1a, f.r1b));
    end_i = 1'b1;
    send(fbc_word(2'd3, f.r2a, f.r2b));
    wait_cycles(2);
    end_i = 1'b0;
    chk("flush_cmpl_err_cnt", seq_err_cnt_o, exp_err);
    chk("flush_cmpl_done", done_pulses - d0, 1);
    chk("flush_cmpl_frame_cnt", frame_cnt_o, 6);

    // Marker-0 word inside a frame is dropped without disturbing the sequence
    f = mkf(29'h0777777, 32'h7777_0007, 24'h700000);
    sb.push_back(f);
    send(enc_word(f.w, f.x));
    send(64'h0123_4567_89AB_CDEF);
    send(fbc_word(2'd1, f.ia, f.ib));
    send(fbc_word(2'd2, f.r1a, f.r1b));
    send(fbc_word(2'd3, f.r2a, f.r2b));
    wait_cycles(2);
    exp_err++;
    chk("marker_err_cnt", seq_err_cnt_o, exp_err);
    chk("marker_frame_cnt", frame_cnt_o, 7);

    // Pad bit 60 set in word 1
    f = mkf(29'h0888888, 32'h8888_0008, 24'h800000);
    sb.push_back(f);
    send(enc_word(f.w, f.x));
    send(fbc_word(2'd1, f.ia, f.ib) | 64'h1000_0000_0000_0000);
    send(fbc_word(2'd2, f.r1a, f.r1b));
    send(fbc_word(2'd3, f.r2a, f.r2b));
    wait_cycles(2);
`ifdef PMT_UNPACK_PAD_CHECK_EN
    exp_err++;
`endif
    chk("pad_err_cnt", seq_err_cnt_o, exp_err);
    chk("pad_frame_cnt", frame_cnt_o, 8);

    // Clear in the middle of a frame
    send(enc_word(29'h0999, 32'h9));
    send(fbc_word(2'd1, 24'h9, 24'h9));
    @(posedge clk_i);
    #1 clr_i = 1'b1;
    @(posedge clk_i);
    #1 clr_i = 1'b0;
    @(negedge clk_i);
    chk("clr_counters", {frame_cnt_o, seq_err_cnt_o}, 0);
    chk("clr_frame_vld", frame_vld_o, 1'b0);

    // Saturation: 65540 back-to-back marker-0 words
    @(negedge clk_i);
    in_vld_i  = 1'b1;
    in_data_i = 64'h0;
    repeat (65540) @(posedge clk_i);
    #1 in_vld_i = 1'b0;
    wait_cycles(2);
    chk("sat_err_cnt", seq_err_cnt_o, 16'hFFFF);
    chk("sat_frame_cnt", frame_cnt_o, 0);

    f = mkf(29'h0AAAAAA, 32'hAAAA_000A, 24'hA00000);
    sb.push_back(f);
    send_frame(f);
    wait_cycles(2);
    chk("post_clr_frame_cnt", frame_cnt_o, 1);
    chk("post_clr_err_cnt", seq_err_cnt_o, 16'hFFFF);

    wait_cycles(3);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
